// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with programmable terminal value, variable step,
// wrap or saturate handling, synchronous clear/load and overflow/underflow flags.
module updown_counter_param #(
    parameter int width_p      = 8,
    parameter int max_val_p    = 2**width_p - 1,
    parameter int step_width_p = 4,
    parameter int saturate_p   = 0,
    parameter int reset_val_p  = 0
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    clear_i,
    input  logic                    load_i,
    input  logic [width_p-1:0]      load_val_i,
    input  logic                    en_i,
    input  logic                    up_i,
    input  logic                    down_i,
    input  logic [step_width_p-1:0] step_i,
    output logic [width_p-1:0]      count_o,
    output logic                    at_max_o,
    output logic                    at_min_o,
    output logic                    wrap_o,
    output logic                    ovf_sticky_o,
    output logic                    udf_sticky_o
);

    // Two guard bits keep count+step and count+max+1 exact before the bound compare.
    localparam int ext_w = width_p + 2;
    localparam logic [ext_w-1:0]   max_x = ext_w'(max_val_p);
    localparam logic [ext_w-1:0]   one_x = ext_w'(1);
    localparam logic [width_p-1:0] max_c = width_p'(max_val_p);
    localparam logic [width_p-1:0] rst_c = width_p'(reset_val_p);

    logic [ext_w-1:0]   cnt_x;
    logic [ext_w-1:0]   step_x;
    logic [ext_w-1:0]   s_eff;
    logic [ext_w-1:0]   load_x;
    logic [ext_w-1:0]   sum_up;
    logic [ext_w-1:0]   dif_dn;
    logic               do_up;
    logic               do_down;
    logic               ovf;
    logic               udf;
    logic [width_p-1:0] count_n;
    logic               wrap_n;
    logic               ovf_n;
    logic               udf_n;

    always_comb begin
        cnt_x   = ext_w'(count_o);
        step_x  = ext_w'(step_i);
        s_eff   = (step_x > max_x) ? max_x : step_x;
        load_x  = ext_w'(load_val_i);
        do_up   = en_i & up_i & ~down_i;
        do_down = en_i & down_i & ~up_i;
        sum_up  = cnt_x + s_eff;
        dif_dn  = cnt_x - s_eff;
        ovf     = do_up & (sum_up > max_x);
        udf     = do_down & (s_eff > cnt_x);

        count_n = count_o;
        wrap_n  = 1'b0;
        ovf_n   = ovf_sticky_o;
        udf_n   = udf_sticky_o;

        if (clear_i) begin
            count_n = rst_c;
            ovf_n   = 1'b0;
            udf_n   = 1'b0;
        end else if (load_i) begin
            count_n = (load_x > max_x) ? max_c : load_val_i;
        end else if (do_up) begin
            if (ovf) begin
                wrap_n  = 1'b1;
                ovf_n   = 1'b1;
                count_n = (saturate_p != 0) ? max_c : width_p'(sum_up - max_x - one_x);
            end else begin
                count_n = width_p'(sum_up);
            end
        end else if (do_down) begin
            if (udf) begin
                wrap_n  = 1'b1;
                udf_n   = 1'b1;
                count_n = (saturate_p != 0) ? '0 : width_p'(cnt_x + max_x + one_x - s_eff);
            end else begin
                count_n = width_p'(dif_dn);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            count_o      <= rst_c;
            wrap_o       <= 1'b0;
            ovf_sticky_o <= 1'b0;
            udf_sticky_o <= 1'b0;
        end else begin
            count_o      <= count_n;
            wrap_o       <= wrap_n;
            ovf_sticky_o <= ovf_n;
            udf_sticky_o <= udf_n;
        end
    end

    assign at_max_o = (count_o == max_c);
    assign at_min_o = (count_o == '0);

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: three configurations (legacy 4-bit wrap,
// max 9 wrap, 8-bit saturate at 200) driven in lockstep against a modulo model.
module tb_updown_counter_param;

    logic       clk_sys = 1'b0;
    logic       reset_i = 1'b1;
    logic       c_clear = 1'b0;
    logic       c_load  = 1'b0;
    logic [7:0] c_lv    = '0;
    logic       c_en    = 1'b0;
    logic       c_up    = 1'b0;
    logic       c_down  = 1'b0;
    logic [3:0] c_step  = '0;

    logic [3:0] cnt0, cnt1;
    logic [7:0] cnt2;
    logic [2:0] amax_s, amin_s, wrap_s, ovf_s, udf_s;

    int checks = 0;
    int errors = 0;

    int cfg_w   [3] = '{4, 4, 8};
    int cfg_max [3] = '{15, 9, 200};
    int cfg_sat [3] = '{0, 0, 1};
    int cfg_rv  [3] = '{0, 0, 7};

    int m_cnt  [3];
    int m_wrap [3];
    int m_ovf  [3];
    int m_udf  [3];

    always #5 clk_sys = ~clk_sys;

    updown_counter_param #(.width_p(4), .max_val_p(15), .step_width_p(4),
                           .saturate_p(0), .reset_val_p(0)) u_legacy (
        .clk_i(clk_sys), .reset_i(reset_i), .clear_i(c_clear), .load_i(c_load),
        .load_val_i(c_lv[3:0]), .en_i(c_en), .up_i(c_up), .down_i(c_down),
        .step_i(c_step), .count_o(cnt0), .at_max_o(amax_s[0]), .at_min_o(amin_s[0]),
        .wrap_o(wrap_s[0]), .ovf_sticky_o(ovf_s[0]), .udf_sticky_o(udf_s[0]));

    updown_counter_param #(.width_p(4), .max_val_p(9), .step_width_p(4),
                           .saturate_p(0), .reset_val_p(0)) u_mod9 (
        .clk_i(clk_sys), .reset_i(reset_i), .clear_i(c_clear), .load_i(c_load),
        .load_val_i(c_lv[3:0]), .en_i(c_en), .up_i(c_up), .down_i(c_down),
        .step_i(c_step), .count_o(cnt1), .at_max_o(amax_s[1]), .at_min_o(amin_s[1]),
        .wrap_o(wrap_s[1]), .ovf_sticky_o(ovf_s[1]), .udf_sticky_o(udf_s[1]));

    updown_counter_param #(.width_p(8), .max_val_p(200), .step_width_p(4),
                           .saturate_p(1), .reset_val_p(7)) u_sat (
        .clk_i(clk_sys), .reset_i(reset_i), .clear_i(c_clear), .load_i(c_load),
        .load_val_i(c_lv), .en_i(c_en), .up_i(c_up), .down_i(c_down),
        .step_i(c_step), .count_o(cnt2), .at_max_o(amax_s[2]), .at_min_o(amin_s[2]),
        .wrap_o(wrap_s[2]), .ovf_sticky_o(ovf_s[2]), .udf_sticky_o(udf_s[2]));

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int get_cnt(input int i);
        if (i == 0) return int'(cnt0);
        if (i == 1) return int'(cnt1);
        return int'(cnt2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i]  = cfg_rv[i];
            m_wrap[i] = 0;
            m_ovf[i]  = 0;
            m_udf[i]  = 0;
        end
    endtask

    // Counting viewed as arithmetic on the ring 0..max (wrap) or the interval 0..max (saturate).
    task automatic model_edge();
        int s, m, lv;
        for (int i = 0; i < 3; i++) begin
            m = cfg_max[i];
            m_wrap[i] = 0;
            if (c_clear) begin
                m_cnt[i] = cfg_rv[i];
                m_ovf[i] = 0;
                m_udf[i] = 0;
            end else if (c_load) begin
                lv = int'(c_lv) % (1 << cfg_w[i]);
                m_cnt[i] = (lv > m) ? m : lv;
            end else if (c_en && (c_up != c_down)) begin
                s = (int'(c_step) > m) ? m : int'(c_step);
                if (c_up) begin
                    if (m_cnt[i] + s > m) begin
                        m_wrap[i] = 1;
                        m_ovf[i]  = 1;
                    end
                    if (cfg_sat[i] != 0) m_cnt[i] = (m_cnt[i] + s > m) ? m : m_cnt[i] + s;
                    else                 m_cnt[i] = (m_cnt[i] + s) % (m + 1);
                end else begin
                    if (s > m_cnt[i]) begin
                        m_wrap[i] = 1;
                        m_udf[i]  = 1;
                    end
                    if (cfg_sat[i] != 0) m_cnt[i] = (s > m_cnt[i]) ? 0 : m_cnt[i] - s;
                    else                 m_cnt[i] = (m_cnt[i] - s + m + 1) % (m + 1);
                end
            end
        end
    endtask

    task automatic check_all(input string ctx);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s i%0d count", ctx, i), get_cnt(i), m_cnt[i]);
            check($sformatf("%s i%0d wrap", ctx, i), int'(wrap_s[i]), m_wrap[i]);
            check($sformatf("%s i%0d ovf", ctx, i), int'(ovf_s[i]), m_ovf[i]);
            check($sformatf("%s i%0d udf", ctx, i), int'(udf_s[i]), m_udf[i]);
            check($sformatf("%s i%0d at_max", ctx, i), int'(amax_s[i]),
                  (m_cnt[i] == cfg_max[i]) ? 1 : 0);
            check($sformatf("%s i%0d at_min", ctx, i), int'(amin_s[i]),
                  (m_cnt[i] == 0) ? 1 : 0);
        end
    endtask

    task automatic cyc(input string ctx, input bit clr, input bit ld, input int lv,
                       input bit en, input bit up, input bit dn, input int st);
        c_clear = clr;
        c_load  = ld;
        c_lv    = 8'(lv);
        c_en    = en;
        c_up    = up;
        c_down  = dn;
        c_step  = 4'(st);
        @(posedge clk_sys);
        model_edge();
        #1;
        check_all(ctx);
    endtask

    task automatic async_reset(input string ctx);
        reset_i = 1'b0;
        model_reset();
        #1;
        check_all(ctx);
        @(negedge clk_sys);
        reset_i = 1'b1;
    endtask

    initial begin
        int wraps;
        model_reset();
        #3;
        async_reset("reset");
        check("reset legacy count", int'(cnt0), 0);
        check("reset legacy at_min", int'(amin_s[0]), 1);
        cyc("post-reset hold", 0, 0, 0, 0, 1, 0, 1);
        check("post-reset legacy count", int'(cnt0), 0);

        wraps = 0;
        for (int k = 0; k < 20; k++) begin
            cyc("legacy up", 0, 0, 0, 1, 1, 0, 1);
            wraps += int'(wrap_s[0]);
        end
        check("legacy up final", int'(cnt0), 4);
        check("legacy up pulses", wraps, 1);
        check("legacy ovf", int'(ovf_s[0]), 1);
        wraps = 0;
        for (int k = 0; k < 20; k++) begin
            cyc("legacy down", 0, 0, 0, 1, 0, 1, 1);
            wraps += int'(wrap_s[0]);
        end
        check("legacy down final", int'(cnt0), 0);
        check("legacy down pulses", wraps, 1);
        check("legacy udf", int'(udf_s[0]), 1);
        for (int k = 0; k < 20; k++) cyc("legacy both", 0, 0, 0, 1, 1, 1, 1);
        check("legacy both hold", int'(cnt0), 0);

        cyc("mod9 load", 0, 1, 8, 0, 0, 0, 0);
        cyc("mod9 up3", 0, 0, 0, 1, 1, 0, 3);
        check("mod9 up3 count", int'(cnt1), 1);
        check("mod9 up3 wrap", int'(wrap_s[1]), 1);
        cyc("mod9 idle", 0, 0, 0, 0, 0, 0, 3);
        check("mod9 wrap cleared", int'(wrap_s[1]), 0);
        cyc("mod9 down3", 0, 0, 0, 1, 0, 1, 3);
        check("mod9 down3 count", int'(cnt1), 8);
        cyc("mod9 load0", 0, 1, 0, 0, 0, 0, 0);
        cyc("mod9 up9", 0, 0, 0, 1, 1, 0, 9);
        check("mod9 up9 count", int'(cnt1), 9);
        check("mod9 up9 no wrap", int'(wrap_s[1]), 0);

        cyc("sat clear", 1, 0, 0, 0, 0, 0, 0);
        cyc("sat load198", 0, 1, 198, 0, 0, 0, 0);
        cyc("sat up5", 0, 0, 0, 1, 1, 0, 5);
        check("sat up5 count", int'(cnt2), 200);
        check("sat up5 at_max", int'(amax_s[2]), 1);
        check("sat up5 wrap", int'(wrap_s[2]), 1);
        cyc("sat up5 again", 0, 0, 0, 1, 1, 0, 5);
        check("sat hold count", int'(cnt2), 200);
        check("sat hold wrap", int'(wrap_s[2]), 1);
        cyc("sat load3", 0, 1, 3, 0, 0, 0, 0);
        cyc("sat down7", 0, 0, 0, 1, 0, 1, 7);
        check("sat down7 count", int'(cnt2), 0);
        check("sat down7 udf", int'(udf_s[2]), 1);

        cyc("prio clr", 1, 1, 50, 1, 1, 0, 1);
        check("prio clr count", int'(cnt2), 7);
        check("prio clr udf", int'(udf_s[2]), 0);
        cyc("prio load250", 0, 1, 250, 0, 0, 0, 0);
        check("prio load clamp", int'(cnt2), 200);
        cyc("prio load+up", 0, 1, 20, 1, 1, 0, 4);
        check("prio load+up", int'(cnt2), 20);

        cyc("race load", 0, 1, 200, 0, 0, 0, 0);
        cyc("race clr+ovf", 1, 0, 0, 1, 1, 0, 1);
        check("race ovf", int'(ovf_s[2]), 0);
        check("race wrap", int'(wrap_s[2]), 0);
        cyc("race load2", 0, 1, 200, 0, 0, 0, 0);
        cyc("race ovf again", 0, 0, 0, 1, 1, 0, 1);
        check("race ovf again", int'(ovf_s[2]), 1);

        for (int k = 0; k < 600; k++) begin
            if (k % 97 == 50) async_reset("mid reset");
            cyc("rand", ($urandom % 24) == 0, ($urandom % 8) == 0, int'($urandom % 256),
                ($urandom % 4) != 0, 1'($urandom), 1'($urandom), int'($urandom % 16));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
